// File: rtl/clock_measure.sv
// clock_measure: measures rise-to-rise period and rise-to-fall high time of an
// asynchronous clock/PWM input, in fast_clk cycles.
//
// Parameters:
//   WIDTH       - counter and result width; largest measurable period 2^WIDTH-1
//   SYNC_STAGES - synchronizer depth on sig_in (>= 2)
//   LOCK_COUNT  - identical consecutive measurements needed for locked (>= 1)
// Ports:
//   fast_clk   in   sampling clock, posedge
//   rst        in   synchronous active-high reset
//   enable     in   measurement enable
//   sig_in     in   signal under measurement (asynchronous)
//   period     out  last measured period
//   duty_cycle out  last measured high time
//   valid      out  one-cycle pulse when period/duty_cycle update
//   locked     out  last LOCK_COUNT measurements identical
//   overflow   out  no edge seen for 2^WIDTH-1 cycles
module clock_measure #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 2
) (
    input  logic             fast_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             valid,
    output logic             locked,
    output logic             overflow
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_OVF  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] hi_len, hi_len_n;
    logic [WIDTH-1:0] period_n, duty_n;
    logic [MW-1:0]    match, match_n;
    logic             valid_n, locked_n, overflow_n;

    // Synchronizer and edge-history flops; these run regardless of enable.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // State and registered outputs.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi_len     <= '0;
            period     <= '0;
            duty_cycle <= '0;
            match      <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hi_len     <= hi_len_n;
            period     <= period_n;
            duty_cycle <= duty_n;
            match      <= match_n;
            valid      <= valid_n;
            locked     <= locked_n;
            overflow   <= overflow_n;
        end
    end

    // Next-state, counter, measurement and lock tracking.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hi_len_n   = hi_len;
        period_n   = period;
        duty_n     = duty_cycle;
        match_n    = match;
        valid_n    = 1'b0;
        locked_n   = locked;
        overflow_n = 1'b0;

        if (!enable) begin
            state_n  = ST_IDLE;
            cnt_n    = '0;
            match_n  = '0;
            locked_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_ARM;
                    cnt_n   = '0;
                end
                ST_ARM: begin
                    // First rise only starts a measurement.
                    cnt_n = '0;
                    if (rise) begin
                        state_n = ST_HIGH;
                        cnt_n   = WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    cnt_n = cnt + WIDTH'(1);
                    if (fall) begin
                        hi_len_n = cnt;
                        state_n  = ST_LOW;
                    end else if (cnt == CNT_MAX) begin
                        state_n = ST_OVF;
                    end
                end
                ST_LOW: begin
                    cnt_n = cnt + WIDTH'(1);
                    if (rise) begin
                        cnt_n    = WIDTH'(1);
                        period_n = cnt;
                        duty_n   = hi_len;
                        valid_n  = 1'b1;
                        state_n  = ST_HIGH;
                        // match == 0 marks "no previous measurement to compare".
                        if (match == '0) begin
                            match_n = MW'(1);
                        end else if ((cnt == period) && (hi_len == duty_cycle)) begin
                            match_n = (match >= LOCK_TGT) ? LOCK_TGT : match + MW'(1);
                        end else begin
                            match_n = MW'(1);
                        end
                        locked_n = (match_n >= LOCK_TGT);
                    end else if (cnt == CNT_MAX) begin
                        state_n = ST_OVF;
                    end
                end
                ST_OVF: begin
                    if (rise) begin
                        state_n = ST_HIGH;
                        cnt_n   = WIDTH'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        // Overflow drops lock immediately and forgets the last measurement.
        if (state_n == ST_OVF) begin
            overflow_n = 1'b1;
            match_n    = '0;
            locked_n   = 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_measure.sv
// Directed bench for clock_measure: a generator drives sig_in on negedges,
// expected (period, duty, locked) triples are queued on every measurement-
// completing rise and checked when valid pulses.
module tb_clock_measure;

    logic       fast_clk;
    logic       rst;
    logic       enable;
    logic       sig_in;
    logic [7:0] period;
    logic [7:0] duty_cycle;
    logic       valid;
    logic       locked;
    logic       overflow;

    clock_measure #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .LOCK_COUNT (2)
    ) dut (
        .fast_clk  (fast_clk),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .duty_cycle(duty_cycle),
        .valid     (valid),
        .locked    (locked),
        .overflow  (overflow)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    typedef struct {
        int p;
        int d;
        int lk;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: period in flight, last queued measurement, lock run.
    bit   have_prev = 1'b0;
    int   prev_p = 0;
    int   prev_d = 0;
    int   last_p = -1;
    int   last_d = -1;
    int   m_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic forget();
        have_prev = 1'b0;
        m_cnt     = 0;
    endtask

    // A rise completes the period in flight (if any) and starts a new one.
    task automatic on_rise(input int p, input int d);
        exp_t e;
        if (have_prev) begin
            if (m_cnt == 0 || prev_p != last_p || prev_d != last_d) m_cnt = 1;
            else if (m_cnt < 2) m_cnt++;
            e.p = prev_p;
            e.d = prev_d;
            e.lk = (m_cnt >= 2) ? 1 : 0;
            q.push_back(e);
            last_p = prev_p;
            last_d = prev_d;
        end
        prev_p    = p;
        prev_d    = d;
        have_prev = 1'b1;
    endtask

    task automatic gen(input int p, input int d, input int n, input bit rec);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            if (rec) on_rise(p, d);
            repeat (d) @(negedge fast_clk);
            sig_in = 1'b0;
            repeat (p - d) @(negedge fast_clk);
        end
    endtask

    initial begin
        exp_t e;
        rst    = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;

        // Scoreboard consumer: sample just after each active edge.
        fork
            forever begin
                @(posedge fast_clk);
                #1;
                if (valid === 1'b1) begin
                    check("valid_expected", 32'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("period", period, e.p);
                        check("duty_cycle", duty_cycle, e.d);
                        check("locked_at_valid", locked, e.lk);
                        check("overflow_at_valid", overflow, 0);
                    end
                end
            end
        join_none

        repeat (3) @(negedge fast_clk);
        check("rst_period", period, 0);
        check("rst_duty", duty_cycle, 0);
        check("rst_valid", valid, 0);
        check("rst_locked", locked, 0);
        check("rst_overflow", overflow, 0);
        rst    = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge fast_clk);

        // Steady 10/3, then a clean switch to 10/5.
        gen(10, 3, 5, 1'b1);
        check("locked_10_3", locked, 1);
        gen(10, 5, 4, 1'b1);
        check("locked_10_5", locked, 1);

        // Minimum and maximum measurable periods.
        gen(2, 1, 6, 1'b1);
        gen(255, 254, 3, 1'b1);

        // Stuck high: overflow and lock loss.
        sig_in = 1'b1;
        on_rise(0, 0);
        forget();
        repeat (300) @(negedge fast_clk);
        check("ovf_set", overflow, 1);
        check("ovf_locked", locked, 0);
        sig_in = 1'b0;
        repeat (5) @(negedge fast_clk);
        check("ovf_hold_on_fall", overflow, 1);
        gen(8, 4, 1, 1'b1);
        check("ovf_cleared", overflow, 0);
        gen(8, 4, 3, 1'b1);

        // Disable for 20 cycles while the input keeps toggling.
        gen(10, 3, 3, 1'b1);
        enable = 1'b0;
        @(negedge fast_clk);
        check("dis_valid", valid, 0);
        check("dis_locked", locked, 0);
        check("dis_overflow", overflow, 0);
        check("dis_period_hold", period, 10);
        check("dis_duty_hold", duty_cycle, 3);
        gen(10, 3, 2, 1'b0);
        check("dis_locked_end", locked, 0);
        check("dis_period_end", period, 10);
        enable = 1'b1;
        forget();
        gen(10, 3, 4, 1'b1);

        // Reset pulse while in HIGH.
        sig_in = 1'b1;
        on_rise(10, 3);
        repeat (5) @(negedge fast_clk);
        rst    = 1'b1;
        sig_in = 1'b0;
        @(negedge fast_clk);
        check("midrst_period", period, 0);
        check("midrst_duty", duty_cycle, 0);
        check("midrst_valid", valid, 0);
        check("midrst_locked", locked, 0);
        check("midrst_overflow", overflow, 0);
        repeat (2) @(negedge fast_clk);
        rst = 1'b0;
        forget();
        repeat (3) @(negedge fast_clk);
        gen(10, 3, 4, 1'b1);
        check("post_rst_locked", locked, 1);

        repeat (20) @(negedge fast_clk);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
